// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, bit positions, exception codes, vectors, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cp0_pkg;

    // mfc0/mtc0 register select values
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // Status bit positions
    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;

    // Cause bit positions
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_HWIP_LO = 10;
    localparam int CAUSE_TIMER   = 15;
    localparam int CAUSE_IV      = 23;

    // ExcCode values
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_TR  = 5'd13;

    // Offsets from the vector base
    localparam logic [31:0] VEC_OFS_GEN = 32'h0000_0180;
    localparam logic [31:0] VEC_OFS_INT = 32'h0000_0200;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2
    } cp0_state_e;

    // Interrupts use the dedicated vector only when Cause.IV is set.
    function automatic logic [31:0] vec_offset(input logic [4:0] code, input logic iv);
        return ((code == EXC_INT) && iv) ? VEC_OFS_INT : VEC_OFS_GEN;
    endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// CP0 <-> core bundle: mtc0/mfc0 access, irq lines, trap/eret events, exception redirect.
// Latency: n/a (wiring only); rd is combinational from addr inside the slave.
// Backpressure: none; all events are single-cycle pulses or levels.
// Ports: we/addr/wd (mtc0), rd (mfc0), irq (async levels), trap/eret (pulses),
//        pc_cur (return PC), exc_take/exc_vec (redirect), exl (handler active).
interface cp0_ctrl_if #(
    parameter int unsigned N_IRQ = 6
);
    logic             we;
    logic [4:0]       addr;
    logic [31:0]      wd;
    logic [31:0]      rd;
    logic [N_IRQ-1:0] irq;
    logic             trap;
    logic [31:0]      pc_cur;
    logic             eret;
    logic             exc_take;
    logic [31:0]      exc_vec;
    logic             exl;

    modport master (
        output we, addr, wd, irq, trap, pc_cur, eret,
        input  rd, exc_take, exc_vec, exl
    );

    modport slave (
        input  we, addr, wd, irq, trap, pc_cur, eret,
        output rd, exc_take, exc_vec, exl
    );
endinterface

// File: rtl/cp0_irq_sync.sv
// Per-bit flop-chain synchroniser for asynchronous level interrupt lines.
// Latency: STAGES clock edges from d_i to q_o.
// Backpressure: none.
// Ports: clk_i, rst_ni (async active-low), d_i (async levels), q_o (synchronised levels).
module cp0_irq_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_ctrl.sv
// MIPS-style CP0: Status/Cause/EPC/Count/Compare, irq sync, trap/irq arbitration, exception FSM.
// Latency: event seen at edge n -> exc_take during cycle n+1; irq adds SYNC_STAGES cycles.
// Backpressure: none; new exceptions are held off while EXL=1 (trap kept pending).
// Ports: clk_i, rst_ni (async active-low), bus (cp0_ctrl_if.slave).
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int unsigned N_IRQ       = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          TIMER_EN    = 1'b1,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    cp0_ctrl_if.slave  bus
);

    cp0_state_e       state_q, state_d;
    logic [4:0]       code_q, code_d;
    logic             ie_q, ie_d;
    logic             exl_q, exl_d;
    logic [7:0]       im_q, im_d;
    logic             iv_q, iv_d;
    logic [1:0]       swip_q, swip_d;
    logic [4:0]       exccode_q, exccode_d;
    logic [31:0]      epc_q, epc_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             timer_pend_q, timer_pend_d;
    logic             trap_pend_q, trap_pend_d;

    logic [N_IRQ-1:0] irq_s;
    logic [7:0]       ip;
    logic             int_pend;
    logic             wr_status, wr_cause, wr_epc, wr_count, wr_compare;

    cp0_irq_sync #(
        .WIDTH  (N_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (bus.irq),
        .q_o    (irq_s)
    );

    assign wr_status  = bus.we && (bus.addr == REG_STATUS);
    assign wr_cause   = bus.we && (bus.addr == REG_CAUSE);
    assign wr_epc     = bus.we && (bus.addr == REG_EPC);
    assign wr_count   = bus.we && (bus.addr == REG_COUNT)   && TIMER_EN;
    assign wr_compare = bus.we && (bus.addr == REG_COMPARE) && TIMER_EN;

    // Cause.IP[15:8]: software bits, live synchronised irq levels, timer folded into bit 15.
    always_comb begin
        ip = '0;
        ip[1:0] = swip_q;
        ip[CAUSE_HWIP_LO - CAUSE_IP_LO +: N_IRQ] = irq_s;
        if (TIMER_EN) ip[CAUSE_TIMER - CAUSE_IP_LO] = ip[CAUSE_TIMER - CAUSE_IP_LO] | timer_pend_q;
    end

    assign int_pend = ie_q && (|(ip & im_q));

    // Count/Compare; a Compare write clears the pending match even if one occurs that cycle.
    always_comb begin
        count_d      = count_q + 32'd1;
        compare_d    = compare_q;
        timer_pend_d = timer_pend_q;
        if (count_q == compare_q) timer_pend_d = 1'b1;
        if (wr_count) count_d = bus.wd;
        if (wr_compare) begin
            compare_d    = bus.wd;
            timer_pend_d = 1'b0;
        end
        if (!TIMER_EN) begin
            count_d      = '0;
            compare_d    = '0;
            timer_pend_d = 1'b0;
        end
    end

    // Register writes and exception FSM; FSM updates override software writes in TAKE.
    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        ie_d          = ie_q;
        exl_d         = exl_q;
        im_d          = im_q;
        iv_d          = iv_q;
        swip_d        = swip_q;
        exccode_d     = exccode_q;
        epc_d         = epc_q;
        trap_pend_d   = trap_pend_q | bus.trap;
        bus.exc_take  = 1'b0;
        bus.exc_vec   = '0;

        if (wr_status) begin
            ie_d  = bus.wd[STATUS_IE];
            exl_d = bus.wd[STATUS_EXL];
            im_d  = bus.wd[STATUS_IM_LO +: 8];
        end
        if (wr_cause) begin
            iv_d   = bus.wd[CAUSE_IV];
            swip_d = bus.wd[CAUSE_IP_LO +: 2];
        end
        if (wr_epc) epc_d = bus.wd;

        unique case (state_q)
            ST_RUN: begin
                if (!exl_q) begin
                    if (trap_pend_q || bus.trap) begin
                        state_d = ST_TAKE;
                        code_d  = EXC_TR;
                    end else if (int_pend) begin
                        state_d = ST_TAKE;
                        code_d  = EXC_INT;
                    end
                end
            end
            ST_TAKE: begin
                bus.exc_take = 1'b1;
                bus.exc_vec  = VEC_BASE + vec_offset(code_q, iv_q);
                epc_d        = bus.pc_cur;
                exl_d        = 1'b1;
                exccode_d    = code_q;
                // A trap arriving in this very cycle is a new one and stays pending.
                if (code_q == EXC_TR) trap_pend_d = bus.trap;
                state_d      = ST_HANDLER;
            end
            ST_HANDLER: begin
                // Return on eret or when software writes EXL to 0.
                if (bus.eret || !exl_d) begin
                    exl_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_RUN;
            code_q       <= '0;
            ie_q         <= 1'b0;
            exl_q        <= 1'b0;
            im_q         <= '0;
            iv_q         <= 1'b0;
            swip_q       <= '0;
            exccode_q    <= '0;
            epc_q        <= '0;
            count_q      <= '0;
            compare_q    <= '0;
            timer_pend_q <= 1'b0;
            trap_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            ie_q         <= ie_d;
            exl_q        <= exl_d;
            im_q         <= im_d;
            iv_q         <= iv_d;
            swip_q       <= swip_d;
            exccode_q    <= exccode_d;
            epc_q        <= epc_d;
            count_q      <= count_d;
            compare_q    <= compare_d;
            timer_pend_q <= timer_pend_d;
            trap_pend_q  <= trap_pend_d;
        end
    end

    assign bus.exl = exl_q;

    // mfc0 read mux; absent and unimplemented registers read 0.
    always_comb begin
        bus.rd = '0;
        case (bus.addr)
            REG_COUNT:   if (TIMER_EN) bus.rd = count_q;
            REG_COMPARE: if (TIMER_EN) bus.rd = compare_q;
            REG_STATUS: begin
                bus.rd[STATUS_IM_LO +: 8] = im_q;
                bus.rd[STATUS_EXL]        = exl_q;
                bus.rd[STATUS_IE]         = ie_q;
            end
            REG_CAUSE: begin
                bus.rd[CAUSE_IV]          = iv_q;
                bus.rd[CAUSE_IP_LO +: 8]  = ip;
                bus.rd[CAUSE_EXC_LO +: 5] = exccode_q;
            end
            REG_EPC:     bus.rd = epc_q;
            default:     bus.rd = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: stimulus pushes expected redirects, a monitor checks them.
// Latency: expected take cycles derived from sync depth and the one-cycle decision rule.
// Backpressure: none; every wait on the DUT is bounded.
`timescale 1ns/1ps
module tb_cp0_ctrl;
    import cp0_pkg::*;

    localparam int unsigned N_IRQ       = 6;
    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [31:0] VEC_BASE    = 32'h0000_0000;
    localparam logic [31:0] FAR_CMP     = 32'hFFFF_0000;

    typedef struct {
        int          cyc;
        logic [31:0] vec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic exl_chk_pend = 1'b0;
    logic m_iv = 1'b0;
    logic [31:0] m_status = 32'h0;

    cp0_ctrl_if #(.N_IRQ(N_IRQ)) bus ();

    cp0_ctrl #(
        .N_IRQ       (N_IRQ),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMER_EN    (1'b1),
        .VEC_BASE    (VEC_BASE)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Handler address from the architectural rule, independent of the DUT.
    function automatic logic [31:0] ref_vec(input logic [4:0] code, input logic iv);
        if (code == 5'd0 && iv) return VEC_BASE + 32'h200;
        return VEC_BASE + 32'h180;
    endfunction

    task automatic push_exp(input int c, input logic [4:0] code);
        exp_t e;
        e.cyc = c;
        e.vec = ref_vec(code, m_iv);
        exp_q.push_back(e);
    endtask

    // Monitor: every redirect must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exl_chk_pend) begin
                check("exl after take", {31'h0, bus.exl}, 32'h1);
                exl_chk_pend = 1'b0;
            end
            if (bus.exc_take) begin
                if (exp_q.size() == 0) begin
                    check("exc_take with nothing expected", {31'h0, bus.exc_take}, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("take cycle", cyc, mon_e.cyc);
                    check("exc_vec", bus.exc_vec, mon_e.vec);
                    exl_chk_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.addr = a; bus.wd = d;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(name, bus.rd, exp);
    endtask

    task automatic wait_exl(input logic v, input string name);
        int n = 0;
        while (bus.exl !== v && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'h0, bus.exl}, {31'h0, v});
    endtask

    task automatic enter_check(input logic [31:0] pc, input logic [4:0] code, input string name);
        wait_exl(1'b1, {name, " exl"});
        rd_check({name, " epc"}, REG_EPC, pc);
        bus.addr = REG_CAUSE;
        #1;
        check({name, " exccode"}, 32'(bus.rd[6:2]), 32'(code));
    endtask

    // Leave the handler by eret or by clearing EXL in software, chosen at random.
    task automatic do_return(input bit follow, input logic [4:0] code);
        if (follow) push_exp(cyc + 2, code);
        if ($urandom_range(0, 1) == 1) begin
            bus.eret = 1'b1;
            @(negedge clk);
            bus.eret = 1'b0;
        end else begin
            mtc0(REG_STATUS, m_status);
        end
        check("exl cleared on return", {31'h0, bus.exl}, 32'h0);
    endtask

    initial begin
        int          line;
        int          k;
        logic [31:0] pc, pc2;
        logic [31:0] cnt0;

        bus.we = 1'b0; bus.addr = '0; bus.wd = '0; bus.irq = '0;
        bus.trap = 1'b0; bus.pc_cur = '0; bus.eret = 1'b0;

        // Reset state
        tick(2);
        check("reset exl", {31'h0, bus.exl}, 32'h0);
        check("reset exc_take", {31'h0, bus.exc_take}, 32'h0);
        check("reset exc_vec", bus.exc_vec, 32'h0);
        rd_check("reset count", REG_COUNT, 32'h0);
        rd_check("reset compare", REG_COMPARE, 32'h0);
        rd_check("reset status", REG_STATUS, 32'h0);
        rd_check("reset cause", REG_CAUSE, 32'h0);
        rd_check("reset epc", REG_EPC, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        mtc0(REG_COMPARE, FAR_CMP);

        // Interrupts on random lines and vectors
        for (int it = 0; it < 4; it++) begin
            line = $urandom_range(0, N_IRQ - 1);
            m_iv = 1'($urandom_range(0, 1));
            pc   = $urandom & 32'hFFFF_FFFC;
            if (it == 0) begin line = 0; m_iv = 1'b0; pc = 32'h0000_1004; end
            if (it == 1) begin line = 0; m_iv = 1'b1; end
            m_status = 32'h1 | (32'h1 << (10 + line));
            mtc0(REG_STATUS, m_status);
            mtc0(REG_CAUSE, {8'h0, m_iv, 23'h0});
            bus.pc_cur = pc;
            push_exp(cyc + SYNC_STAGES + 1, EXC_INT);
            bus.irq[line] = 1'b1;
            enter_check(pc, EXC_INT, "irq");
            rd_check("status in handler", REG_STATUS, m_status | 32'h2);
            rd_check("cause in handler", REG_CAUSE, {8'h0, m_iv, 23'h0} | (32'h1 << (10 + line)));
            bus.irq = '0;
            tick(SYNC_STAGES + 2);
            do_return(1'b0, EXC_INT);
        end

        // Trap with IV=1, plus a Status write landing in the TAKE cycle
        m_iv = 1'b1;
        mtc0(REG_CAUSE, 32'h0080_0000);
        pc = $urandom & 32'hFFFF_FFFC;
        bus.pc_cur = pc;
        push_exp(cyc + 1, EXC_TR);
        bus.trap = 1'b1;
        @(negedge clk);
        bus.trap = 1'b0;
        m_status = 32'h1 | ($urandom & 32'h0000_FF00);
        mtc0(REG_STATUS, m_status);
        enter_check(pc, EXC_TR, "trap");
        rd_check("status written during take", REG_STATUS, m_status | 32'h2);
        do_return(1'b0, EXC_TR);

        // Trap and irq in the same cycle; irq follows after return
        line = $urandom_range(0, N_IRQ - 1);
        m_status = 32'h1 | (32'h1 << (10 + line));
        mtc0(REG_STATUS, m_status);
        m_iv = 1'($urandom_range(0, 1));
        mtc0(REG_CAUSE, {8'h0, m_iv, 23'h0});
        pc = $urandom & 32'hFFFF_FFFC;
        bus.pc_cur = pc;
        push_exp(cyc + 1, EXC_TR);
        bus.irq[line] = 1'b1;
        bus.trap = 1'b1;
        @(negedge clk);
        bus.trap = 1'b0;
        enter_check(pc, EXC_TR, "trap+irq");
        pc2 = $urandom & 32'hFFFF_FFFC;
        bus.pc_cur = pc2;
        do_return(1'b1, EXC_INT);
        enter_check(pc2, EXC_INT, "irq after trap");
        bus.irq = '0;
        tick(SYNC_STAGES + 2);
        do_return(1'b0, EXC_INT);

        // Trap inside a handler is deferred until return
        pc = $urandom & 32'hFFFF_FFFC;
        bus.pc_cur = pc;
        push_exp(cyc + 1, EXC_TR);
        bus.trap = 1'b1;
        @(negedge clk);
        bus.trap = 1'b0;
        enter_check(pc, EXC_TR, "first trap");
        tick(2);
        bus.trap = 1'b1;
        @(negedge clk);
        bus.trap = 1'b0;
        tick(5);
        pc2 = $urandom & 32'hFFFF_FFFC;
        bus.pc_cur = pc2;
        do_return(1'b1, EXC_TR);
        enter_check(pc2, EXC_TR, "deferred trap");
        do_return(1'b0, EXC_TR);

        // Glitch on irq between edges and eret in RUN: no exception
        m_status = 32'h0000_FC01;
        mtc0(REG_STATUS, m_status);
        #2 bus.irq = '1;
        #2 bus.irq = '0;
        @(negedge clk);
        bus.eret = 1'b1;
        @(negedge clk);
        bus.eret = 1'b0;
        tick(6);
        check("no exl after glitch", {31'h0, bus.exl}, 32'h0);
        rd_check("cause after glitch", REG_CAUSE, {8'h0, m_iv, 23'h0} | (32'd13 << 2));

        // Timer: Count wraps, matches Compare, interrupt on IP[15]
        m_status = 32'h0000_8001;
        mtc0(REG_STATUS, m_status);
        m_iv = 1'b0;
        mtc0(REG_CAUSE, 32'h0);
        pc = $urandom & 32'hFFFF_FFFC;
        bus.pc_cur = pc;
        mtc0(REG_COMPARE, 32'h1);
        cnt0 = 32'hFFFF_FFFE;
        k = cyc;
        // load edge + edges to reach Compare + one to flag + one to take
        push_exp(k + 1 + int'(32'h1 - cnt0) + 2, EXC_INT);
        mtc0(REG_COUNT, cnt0);
        tick(2);
        rd_check("count wrap", REG_COUNT, cnt0 + 32'd2);
        enter_check(pc, EXC_INT, "timer");
        rd_check("cause timer pending", REG_CAUSE, 32'h0000_8000);
        mtc0(REG_COMPARE, FAR_CMP);
        rd_check("cause after compare write", REG_CAUSE, 32'h0);
        do_return(1'b0, EXC_INT);

        // Asynchronous reset while in the handler
        pc = ($urandom & 32'hFFFF_FFFC) | 32'h100;
        bus.pc_cur = pc;
        push_exp(cyc + 1, EXC_TR);
        bus.trap = 1'b1;
        @(negedge clk);
        bus.trap = 1'b0;
        enter_check(pc, EXC_TR, "pre-reset trap");
        #2 rst_n = 1'b0;
        #1;
        check("exl in reset", {31'h0, bus.exl}, 32'h0);
        check("exc_take in reset", {31'h0, bus.exc_take}, 32'h0);
        rd_check("epc in reset", REG_EPC, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        mtc0(REG_COMPARE, FAR_CMP);
        tick(5);

        check("expectations left", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Parametrised MIPS-style coprocessor 0 for the soft core.
- Holds Status (12), Cause (13), EPC (14), Count (9) and Compare (11).
- Synchronises N_IRQ external interrupt lines and arbitrates traps against interrupts.
- Captures the return PC and drives the exception vector and EXL to the control unit through a RUN/TAKE/HANDLER state machine with an ERET handshake.

Parameters:
- N_IRQ, 6: number of hardware interrupt lines (1..6), mapped to Cause/Status bits 10..10+N_IRQ-1.
- SYNC_STAGES, 2: flops in each irq synchroniser (≥2).
- TIMER_EN, 1: enables Count/Compare; the timer interrupt is ORed into IP bit 15.
- VEC_BASE, 32'h0000_0000: exception vector base address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  mtc0 write enable.
- addr  in  5  CP0 register select for read and write.
- wd  in  32  mtc0 write data.
- rd  out  32  mfc0 read data, combinational from addr.
- irq  in  N_IRQ  external interrupt requests, asynchronous, level-sensitive.
- trap  in  1  ALU trap request, single-cycle synchronous pulse.
- pc_cur  in  32  PC+4 of the current instruction; this is the value saved to EPC.
- eret  in  1  eret executed, single-cycle pulse.
- exc_take  out  1  one-cycle pulse: redirect fetch to exc_vec.
- exc_vec  out  32  handler address, valid while exc_take=1.
- exl  out  1  Status.EXL; the core is in a handler.

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, state RUN, trap_pend 0, exc_take 0, exc_vec 0, exl 0, synchronisers cleared.
- Status writable bits:
  - [0] IE.
  - [1] EXL, writable by software; see the priority rules for simultaneous events.
  - [15:8] IM.
  - All other bits read 0.
- Cause bits:
  - [23] IV, writable.
  - [9:8] software IP, writable.
  - [10+i] = synchronised irq[i]. Read-only; tracks the line each cycle, never latched.
  - [15] additionally ORed with timer_pend when TIMER_EN=1.
  - [6:2] ExcCode, written only by the state machine.
  - All other bits read 0.
- EPC: fully writable through mtc0. Loaded with pc_cur in TAKE.
- Count:
  - Increments by 1 every clock and wraps 32'hFFFF_FFFF→0.
  - An mtc0 write loads wd instead of incrementing that cycle.
- Compare:
  - When Count==Compare (before increment), timer_pend is set.
  - Any write to Compare clears timer_pend. If a match and a Compare write happen in the same cycle, the clear wins.
- Registers absent with TIMER_EN=0, and all unimplemented addresses, read 0; writes to them are ignored.
- trap_pend: set by trap=1 in any state; cleared in the TAKE cycle that services it.
- int_pend = IE & |(Cause[15:8] & Status[15:8]).
- FSM, state RUN:
  - If EXL=0 and trap_pend|trap, go to TAKE with code 13.
  - Else if EXL=0 and int_pend, go to TAKE with code 0.
  - Trap has priority over interrupt.
- FSM, state TAKE (exactly one cycle):
  - exc_take=1 and EPC←pc_cur.
  - Status.EXL←1 and Cause.ExcCode←code.
  - exc_vec = VEC_BASE+0x200 if code=0 and IV=1; otherwise VEC_BASE+0x180.
  - Next state HANDLER.
- FSM, state HANDLER:
  - Wait for eret=1, or for software to clear EXL through mtc0.
  - Then EXL←0 and go to RUN.
  - No new exception is evaluated until the cycle after return to RUN.
- Latency: condition true at edge n → exc_take high during cycle n+1. irq adds SYNC_STAGES cycles before IP is visible.
- Simultaneous mtc0 Status write in TAKE: the write updates IE/IM, but EXL is forced to 1.
- Simultaneous mtc0 Cause write in TAKE: ExcCode comes from the FSM.
- trap arriving in HANDLER: held in trap_pend and taken after return.
- eret in RUN: ignored.
- irq deasserted before TAKE: no exception is taken.
- Reset mid-handler: returns to RUN with EXL=0 and EPC=0.

Decomposition:
- cp0_pkg:
  - Register indices: 9, 11, 12, 13, 14.
  - Status/Cause bit positions.
  - ExcCode constants: EXC_INT=0, EXC_TR=13.
  - Vector offsets: 0x180, 0x200.
  - FSM state enum.
- One sub-module, cp0_irq_sync: a per-bit SYNC_STAGES-deep flop chain, with asynchronous active-low reset.

Test Plan:
- Status=32'h0000_0401, irq[0] rises, pc_cur=32'h0000_1004, IV=0 → exc_take pulse 2+1 cycles later; exc_vec=32'h180, EPC=32'h1004, ExcCode=0, exl=1; eret → exl=0.
- Same setup with IV=1 → exc_vec=32'h200. Then trap pulse with IV=1 → exc_vec=32'h180, ExcCode=13.
- trap and irq[0] asserted in the same cycle → ExcCode=13. After eret, the still-asserted irq[0] is taken next with ExcCode=0.
- trap pulse while exl=1 → no exc_take until eret, then exc_take one cycle later with ExcCode=13.
- Timer: Count=32'hFFFF_FFFE, Compare=32'h1, Status=32'h0000_8001 → Count wraps to 0; match at Count=1; IP[15]=1; exception taken. Compare write → IP[15]=0.
- Assert rst=0 in HANDLER mid-cycle → immediate exl=0, exc_take=0, rd of addr 14 returns 0.
